// File: rtl/mpt_walk_arbiter.sv
// rtl/mpt_walk_arbiter.sv - round-robin arbiter sharing one MPT walker among NUM_REQ requesters
// Optional grant counters enabled by defining MPT_ARB_PERF_EN.
package mpt_pkg;
   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      ACC_READ  = 2'b00,
      ACC_WRITE = 2'b01,
      ACC_EXEC  = 2'b10
   } mpt_access_e;

   typedef enum logic [2:0] {
      NO_ERROR        = 3'b000,
      ACCESS_DENIED   = 3'b001,
      NOT_VALID_ENTRY = 3'b010,
      RESERVED_BITS   = 3'b011,
      LEVEL_FAULT     = 3'b100
   } page_format_fault_e;
endpackage

module mpt_walk_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = mpt_pkg::XLEN,
   parameter int CNT_W   = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*XLEN-1:0]   req_spa_i,
   input  logic [NUM_REQ*2-1:0]      req_access_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic                      rsp_fault_o,
   output logic [2:0]                rsp_error_o,
   output logic                      ptw_req_valid_o,
   input  logic                      ptw_req_ready_i,
   output logic [XLEN-1:0]           ptw_spa_o,
   output logic [1:0]                ptw_access_o,
   input  logic                      ptw_rsp_valid_i,
   input  logic                      ptw_rsp_fault_i,
   input  logic [2:0]                ptw_rsp_error_i,
   output logic                      busy_o
`ifdef MPT_ARB_PERF_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0]  grant_cnt_o
`endif
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_WAIT  = 2'd2;
   localparam logic [1:0] ARB_DRAIN = 2'd3;

   if (NUM_REQ < 2 || CNT_W < 1) begin : g_param_check
      $error("mpt_walk_arbiter: NUM_REQ must be >= 2 and CNT_W >= 1");
   end

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, owner_q, winner;
   logic [IDX_W:0]     cand_sum;
   logic               found, accept, rsp_capture;
   logic [XLEN-1:0]    spa_q;
   logic [1:0]         access_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic               rsp_fault_q;
   logic [2:0]         rsp_error_q;

   // Scan requesters starting at rr_ptr, wrapping past the last index.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      cand_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
         if (!found && req_valid_i[cand_sum[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = cand_sum[IDX_W-1:0];
         end
      end
   end

   assign accept      = (state_q == ARB_IDLE) && found && !flush_i;
   assign rsp_capture = (state_q == ARB_WAIT) && ptw_rsp_valid_i && !flush_i;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = accept && (winner == IDX_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:  if (accept) state_d = ARB_ISSUE;
         ARB_ISSUE: begin
            if (ptw_req_ready_i) state_d = flush_i ? ARB_DRAIN : ARB_WAIT;
            else if (flush_i)    state_d = ARB_IDLE;
         end
         // A flush coinciding with the response drops it and frees the walker at once.
         ARB_WAIT: begin
            if (ptw_rsp_valid_i) state_d = ARB_IDLE;
            else if (flush_i)    state_d = ARB_DRAIN;
         end
         ARB_DRAIN: if (ptw_rsp_valid_i) state_d = ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         spa_q       <= '0;
         access_q    <= '0;
         rsp_valid_q <= '0;
         rsp_fault_q <= 1'b0;
         rsp_error_q <= mpt_pkg::NO_ERROR;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= '0;
         if (accept) begin
            rr_ptr_q <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
            owner_q  <= winner;
            spa_q    <= req_spa_i[int'(winner)*XLEN +: XLEN];
            access_q <= req_access_i[int'(winner)*2 +: 2];
         end
         if (rsp_capture) begin
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_fault_q          <= ptw_rsp_fault_i;
            rsp_error_q          <= ptw_rsp_fault_i ? ptw_rsp_error_i : mpt_pkg::NO_ERROR;
         end
      end
   end

   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_fault_o     = rsp_fault_q;
   assign rsp_error_o     = rsp_error_q;
   assign ptw_req_valid_o = (state_q == ARB_ISSUE);
   assign ptw_spa_o       = spa_q;
   assign ptw_access_o    = access_q;
   assign busy_o          = (state_q != ARB_IDLE);

`ifdef MPT_ARB_PERF_EN
   logic [CNT_W-1:0] grant_cnt_q [NUM_REQ];

   // Saturating so a long run never wraps back to a misleadingly small count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      end else if (accept && (grant_cnt_q[winner] != '1)) begin
         grant_cnt_q[winner] <= grant_cnt_q[winner] + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
      assign grant_cnt_o[g*CNT_W +: CNT_W] = grant_cnt_q[g];
   end
`endif
endmodule
